// File: rtl/slice_mem_mc.sv
// slice_mem_mc: NCH x WPI signed accumulator memory. Each sample is multiplied by one coefficient
// per channel and accumulated; a valid/ready sequencer streams results out, clearing each entry.
module slice_mem_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 9,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned WPI    = 32,
  parameter int unsigned NCH    = 2,
  parameter int unsigned SAT    = 0,
  localparam int unsigned WIN_W = (WPI > 1) ? $clog2(WPI) : 1,
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dvi,
  input  logic [DATA_W-1:0]       data,
  input  logic [NCH*COEF_W-1:0]   svcoeff,
  input  logic                    newwin,
  input  logic                    clr,
  input  logic                    start_dl,
  input  logic                    dl_ready,
  output logic                    dvo,
  output logic [ACC_W-1:0]        regout,
  output logic [WIN_W-1:0]        dl_win,
  output logic [CH_W-1:0]         dl_ch,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    drop
);

  localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
  // One bit wider than the larger operand, so overflow is caught even if a product exceeds ACC_W.
  localparam int unsigned SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StAcc, StDrain, StDl} state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q [NCH][WPI];
  logic [ACC_W-1:0] acc_d [NCH][WPI];

  logic [WIN_W-1:0] wr_win_q, wr_win_d;
  logic [WIN_W-1:0] rd_win_q, rd_win_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic             dvo_q, dvo_d;
  logic [ACC_W-1:0] regout_q, regout_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;

  logic [COEF_W-1:0]        coef    [NCH];
  logic [ACC_W-1:0]         cur     [NCH];
  logic signed [PROD_W-1:0] prod    [NCH];
  logic signed [SUM_W-1:0]  sum     [NCH];
  logic [ACC_W-1:0]         acc_new [NCH];
  logic [NCH-1:0]           ch_ovf;

  logic             xfer;
  logic             ch_last, win_last;
  logic [CH_W-1:0]  next_ch;
  logic [WIN_W-1:0] next_win;

  // Per-channel multiply-accumulate on the currently open window.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      coef[c]   = svcoeff[c*COEF_W +: COEF_W];
      cur[c]    = acc_q[c][wr_win_q];
      prod[c]   = $signed({{(COEF_W+1){1'b0}}, data}) *
                  $signed({{(DATA_W+1){coef[c][COEF_W-1]}}, coef[c]});
      sum[c]    = $signed({{(SUM_W-ACC_W){cur[c][ACC_W-1]}}, cur[c]}) +
                  $signed({{(SUM_W-PROD_W){prod[c][PROD_W-1]}}, prod[c]});
      ch_ovf[c] = !((&sum[c][SUM_W-1:ACC_W-1]) || !(|sum[c][SUM_W-1:ACC_W-1]));
      if (ch_ovf[c] && (SAT != 0)) begin
        acc_new[c] = sum[c][SUM_W-1] ? AccMin : AccMax;
      end else begin
        acc_new[c] = sum[c][ACC_W-1:0];
      end
    end
  end

  always_comb begin
    xfer     = dvo_q & dl_ready;
    ch_last  = (rd_ch_q == CH_W'(NCH - 1));
    win_last = (rd_win_q == WIN_W'(WPI - 1));
    next_ch  = ch_last ? '0 : rd_ch_q + CH_W'(1);
    next_win = ch_last ? rd_win_q + WIN_W'(1) : rd_win_q;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    wr_win_d = wr_win_q;
    rd_win_d = rd_win_q;
    rd_ch_d  = rd_ch_q;
    dvo_d    = dvo_q;
    regout_d = regout_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (clr) begin
      state_d  = StAcc;
      for (int c = 0; c < NCH; c++) begin
        for (int w = 0; w < WPI; w++) begin
          acc_d[c][w] = '0;
        end
      end
      wr_win_d = '0;
      rd_win_d = '0;
      rd_ch_d  = '0;
      dvo_d    = 1'b0;
      regout_d = '0;
      ovf_d    = 1'b0;
      drop_d   = 1'b0;
    end else begin
      if (dvi && (state_q != StAcc)) begin
        drop_d = 1'b1;
      end
      unique case (state_q)
        StAcc: begin
          if (dvi) begin
            for (int c = 0; c < NCH; c++) begin
              acc_d[c][wr_win_q] = acc_new[c];
            end
            if (|ch_ovf) begin
              ovf_d = 1'b1;
            end
            if (newwin) begin
              wr_win_d = (wr_win_q == WIN_W'(WPI - 1)) ? '0 : wr_win_q + WIN_W'(1);
            end
          end
          if (start_dl) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          // The sample taken alongside start_dl has landed by now, so entry (0,0) is final.
          state_d  = StDl;
          dvo_d    = 1'b1;
          regout_d = acc_q[0][0];
          rd_win_d = '0;
          rd_ch_d  = '0;
        end
        StDl: begin
          if (xfer) begin
            acc_d[rd_ch_q][rd_win_q] = '0;
            if (ch_last && win_last) begin
              state_d  = StAcc;
              dvo_d    = 1'b0;
              regout_d = '0;
              rd_win_d = '0;
              rd_ch_d  = '0;
              wr_win_d = '0;
              done_d   = 1'b1;
            end else begin
              rd_ch_d  = next_ch;
              rd_win_d = next_win;
              regout_d = acc_q[next_ch][next_win];
            end
          end
        end
        default: state_d = StAcc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StAcc;
      for (int c = 0; c < NCH; c++) begin
        for (int w = 0; w < WPI; w++) begin
          acc_q[c][w] <= '0;
        end
      end
      wr_win_q <= '0;
      rd_win_q <= '0;
      rd_ch_q  <= '0;
      dvo_q    <= 1'b0;
      regout_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      wr_win_q <= wr_win_d;
      rd_win_q <= rd_win_d;
      rd_ch_q  <= rd_ch_d;
      dvo_q    <= dvo_d;
      regout_q <= regout_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign dvo    = dvo_q;
  assign regout = regout_q;
  assign dl_win = rd_win_q;
  assign dl_ch  = rd_ch_q;
  assign busy   = (state_q != StAcc);
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign drop   = drop_q;

endmodule

// File: tb/tb_slice_mem_mc.sv
// Bench for slice_mem_mc: four instances share one stimulus stream; a monitor pops an expected
// download queue for the selected instance and checks hold stability and done pulses.
module tb_slice_mem_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        dvi = 1'b0, newwin = 1'b0, clr = 1'b0, start_dl = 1'b0, dl_ready = 1'b0;
  logic [7:0]  data = '0;
  logic [17:0] svcoeff = '0;

  always #5 clk = ~clk;

  logic        m_dvo, m_busy, m_done, m_ovf, m_drop;
  logic [31:0] m_regout;
  logic [1:0]  m_win;
  logic [0:0]  m_ch;
  logic        r_dvo, r_busy, r_done, r_ovf, r_drop;
  logic [31:0] r_regout;
  logic [4:0]  r_win;
  logic [0:0]  r_ch;
  logic        s_dvo, s_busy, s_done, s_ovf, s_drop;
  logic [11:0] s_regout;
  logic [1:0]  s_win;
  logic [0:0]  s_ch;
  logic        w_dvo, w_busy, w_done, w_ovf, w_drop;
  logic [11:0] w_regout;
  logic [1:0]  w_win;
  logic [0:0]  w_ch;

  slice_mem_mc #(.WPI(4)) u_m (
    .clk(clk), .reset_n(reset_n), .dvi(dvi), .data(data), .svcoeff(svcoeff), .newwin(newwin),
    .clr(clr), .start_dl(start_dl), .dl_ready(dl_ready), .dvo(m_dvo), .regout(m_regout),
    .dl_win(m_win), .dl_ch(m_ch), .busy(m_busy), .done(m_done), .ovf(m_ovf), .drop(m_drop));

  slice_mem_mc u_r (
    .clk(clk), .reset_n(reset_n), .dvi(dvi), .data(data), .svcoeff(svcoeff), .newwin(newwin),
    .clr(clr), .start_dl(start_dl), .dl_ready(dl_ready), .dvo(r_dvo), .regout(r_regout),
    .dl_win(r_win), .dl_ch(r_ch), .busy(r_busy), .done(r_done), .ovf(r_ovf), .drop(r_drop));

  slice_mem_mc #(.WPI(4), .ACC_W(12), .SAT(1)) u_s (
    .clk(clk), .reset_n(reset_n), .dvi(dvi), .data(data), .svcoeff(svcoeff), .newwin(newwin),
    .clr(clr), .start_dl(start_dl), .dl_ready(dl_ready), .dvo(s_dvo), .regout(s_regout),
    .dl_win(s_win), .dl_ch(s_ch), .busy(s_busy), .done(s_done), .ovf(s_ovf), .drop(s_drop));

  slice_mem_mc #(.WPI(4), .ACC_W(12), .SAT(0)) u_w (
    .clk(clk), .reset_n(reset_n), .dvi(dvi), .data(data), .svcoeff(svcoeff), .newwin(newwin),
    .clr(clr), .start_dl(start_dl), .dl_ready(dl_ready), .dvo(w_dvo), .regout(w_regout),
    .dl_win(w_win), .dl_ch(w_ch), .busy(w_busy), .done(w_done), .ovf(w_ovf), .drop(w_drop));

  typedef struct {int win; int ch; int val;} word_t;
  typedef struct {int d; int c0; int c1; int n; int e0; int e1;} vec_t;

  word_t exp_q[$];
  word_t e;
  int    checks = 0, failures = 0;
  int    done_cnt = 0, xfer_cnt = 0;
  int    mon_sel = 0;
  logic  mv, md;
  int    mr, mw, mc;
  logic  hold = 1'b0;
  int    hold_r, hold_w, hold_c;

  always_comb begin
    mv = 1'b0; md = 1'b0; mr = 0; mw = 0; mc = 0;
    case (mon_sel)
      0: begin mv = m_dvo; md = m_done; mr = $signed(m_regout); mw = m_win; mc = m_ch; end
      1: begin mv = r_dvo; md = r_done; mr = $signed(r_regout); mw = r_win; mc = r_ch; end
      2: begin mv = s_dvo; md = s_done; mr = $signed(s_regout); mw = s_win; mc = s_ch; end
      default: begin mv = w_dvo; md = w_done; mr = $signed(w_regout); mw = w_win; mc = w_ch; end
    endcase
  end

  always @(negedge clk) begin
    if (hold && mv) begin
      checks++;
      if (mr != hold_r || mw != hold_w || mc != hold_c) begin
        failures++;
        $display("FAIL hold_stable: got %0d w%0d c%0d, required %0d w%0d c%0d",
                 mr, mw, mc, hold_r, hold_w, hold_c);
      end
    end
    if (mv && dl_ready) begin
      checks++;
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dl_extra: got %0d w%0d c%0d, required no word", mr, mw, mc);
      end else begin
        e = exp_q.pop_front();
        if (mr != e.val || mw != e.win || mc != e.ch) begin
          failures++;
          $display("FAIL dl_word: got %0d w%0d c%0d, required %0d w%0d c%0d",
                   mr, mw, mc, e.val, e.win, e.ch);
        end
      end
    end
    hold   = mv && !dl_ready;
    hold_r = mr; hold_w = mw; hold_c = mc;
    if (md) done_cnt++;
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int d, input int c0, input int c1, input bit nw);
    dvi = 1'b1; data = 8'(d); svcoeff = {9'(c1), 9'(c0)}; newwin = nw;
    tick();
    dvi = 1'b0; newwin = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic push(input int w, input int c, input int v);
    word_t x;
    x.win = w; x.ch = c; x.val = v;
    exp_q.push_back(x);
  endtask

  task automatic push_zeros(input int nwin);
    for (int w = 0; w < nwin; w++) begin
      push(w, 0, 0);
      push(w, 1, 0);
    end
  endtask

  task automatic start();
    start_dl = 1'b1;
    tick();
    start_dl = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int bound);
    int d0 = done_cnt;
    for (int i = 0; i < bound; i++) begin
      dl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done_cnt != d0) break;
    end
    repeat (3) tick();
    dl_ready = 1'b0;
    check("done_pulses", done_cnt - d0, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_dvo(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (mv) break;
      tick();
    end
    check("dvo_rise", mv, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   mdl[2][32];
    int   x0, d0, d, c0, c1, n;
    tbl[0] = '{7, 3, -2, 8, 168, -112};
    tbl[1] = '{7, 3, -2, 8, 168, -112};
    tbl[2] = '{255, -256, 255, 3, -195840, 195075};
    tbl[3] = '{1, -1, 1, 5, -5, 5};

    // Asynchronous reset state
    #1 reset_n = 1'b0;
    #1;
    check("reset_outs", {m_dvo, m_regout, m_win, m_ch, m_busy, m_done, m_ovf, m_drop}, 0);
    check("reset_outs_r", {r_dvo, r_regout, r_busy, r_done, r_ovf, r_drop}, 0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Table-driven windows, then a read-back proving entries were cleared
    mon_sel = 0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < tbl[w].n; k++) sample(tbl[w].d, tbl[w].c0, tbl[w].c1, k == tbl[w].n - 1);
      push(w, 0, tbl[w].e0);
      push(w, 1, tbl[w].e1);
    end
    start();
    drain(1'b0, 100);
    check("idle_busy", m_busy, 0);
    check("idle_dvo", m_dvo, 0);
    push_zeros(4);
    start();
    drain(1'b1, 200);

    // start_dl with dvi: that sample counts, later ones are dropped; start_dl while busy ignored
    do_clr();
    check("drop_clear", m_drop, 0);
    dvi = 1'b1; data = 8'd5; svcoeff = {9'd0, 9'd1}; start_dl = 1'b1;
    tick();
    start_dl = 1'b0;
    tick();
    tick();
    start_dl = 1'b1;
    tick();
    start_dl = 1'b0; dvi = 1'b0;
    check("busy_dl", m_busy, 1);
    check("drop_set", m_drop, 1);
    check("first_word", $signed(m_regout), 5);
    push(0, 0, 5);
    push(0, 1, 0);
    for (int w = 1; w < 4; w++) begin
      push(w, 0, 0);
      push(w, 1, 0);
    end
    drain(1'b1, 200);
    check("busy_after", m_busy, 0);

    // Overflow: saturating vs wrapping 12-bit accumulators, 32-bit for reference
    do_clr();
    mon_sel = 2;
    for (int k = 0; k < 8; k++) sample(255, 255, -256, k == 7);
    start();
    wait_dvo(5);
    check("sat_val", $signed(s_regout), 2047);
    check("wrap_val", $signed(w_regout), 8);
    check("wide_val", $signed(m_regout), 520200);
    check("sat_ovf", s_ovf, 1);
    check("wrap_ovf", w_ovf, 1);
    check("wide_ovf", m_ovf, 0);
    push(0, 0, 2047);
    push(0, 1, -2048);
    for (int w = 1; w < 4; w++) begin
      push(w, 0, 0);
      push(w, 1, 0);
    end
    drain(1'b1, 200);

    // Random rows into the full-size instance with a random ready pattern
    do_clr();
    mon_sel = 1;
    for (int w = 0; w < 32; w++) begin
      mdl[0][w] = 0;
      mdl[1][w] = 0;
    end
    for (int row = 0; row < 16; row++) begin
      for (int w = 0; w < 32; w++) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          d  = $urandom_range(0, 255);
          c0 = $urandom_range(0, 511) - 256;
          c1 = $urandom_range(0, 511) - 256;
          mdl[0][w] += d * c0;
          mdl[1][w] += d * c1;
          sample(d, c0, c1, k == n - 1);
        end
        if ($urandom_range(0, 7) == 0) begin
          newwin = 1'b1;
          tick();
          newwin = 1'b0;
        end
      end
    end
    for (int w = 0; w < 32; w++) begin
      push(w, 0, mdl[0][w]);
      push(w, 1, mdl[1][w]);
    end
    start();
    drain(1'b1, 2000);

    // clr after three transfers aborts the download
    do_clr();
    mon_sel = 0;
    for (int w = 0; w < 4; w++) begin
      d  = (w == 0) ? 255 : w + 1;
      c0 = (w == 0) ? 255 : 10;
      sample(d, c0, -3, 1'b1);
      push(w, 0, d * c0);
      push(w, 1, -3 * d);
    end
    start();
    wait_dvo(5);
    x0 = xfer_cnt;
    d0 = done_cnt;
    dvi = 1'b1; dl_ready = 1'b1;
    repeat (3) tick();
    check("pre_clr_drop", m_drop, 1);
    check("pre_clr_ovf", s_ovf, 1);
    clr = 1'b1; dl_ready = 1'b0; dvi = 1'b0;
    tick();
    clr = 1'b0;
    check("clr_xfers", xfer_cnt - x0, 3);
    check("clr_dvo", m_dvo, 0);
    check("clr_busy", m_busy, 0);
    check("clr_flags", {m_ovf, m_drop, s_ovf}, 0);
    tick();
    check("clr_no_done", done_cnt - d0, 0);
    exp_q.delete();
    push_zeros(4);
    start();
    drain(1'b0, 100);

    // Asynchronous reset mid-cycle with live accumulators
    do_clr();
    for (int k = 0; k < 3; k++) sample(255, 255, 100, 1'b0);
    check("pre_rst_ovf", s_ovf, 1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_outs", {m_dvo, m_regout, m_win, m_ch, m_busy, m_done, m_ovf, m_drop}, 0);
    check("rst_ovf_s", s_ovf, 0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    push_zeros(4);
    start();
    drain(1'b0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slice_mem_mc.md
Name: slice_mem_mc

Overview:
- Multi-channel, parametrised successor to the single-lane slice accumulator memory in the slicevm process.
- Holds NCH x WPI signed accumulators. Each incoming pixel sample is multiplied by one coefficient per channel and added into the current window's accumulators.
- A download sequencer streams all results out over a valid/ready handshake and clears each accumulator as it is read.
- Sits between the pixel/coefficient feeder and the SVM decision stage.

Parameters:
- DATA_W, 8: unsigned pixel data width.
- COEF_W, 9: signed coefficient width, per channel.
- ACC_W, 32: signed accumulator width. Must be >= DATA_W+COEF_W+1.
- WPI, 32: windows per image row. Depth of each channel's accumulator array.
- NCH, 2: number of parallel coefficient channels.
- SAT, 0: overflow mode. 0 = two's-complement wrap; 1 = saturate to the signed ACC_W limits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- dvi  in  1  data valid; data and svcoeff are sampled when high.
- data  in  DATA_W  unsigned pixel sample.
- svcoeff  in  NCH*COEF_W  signed coefficients; channel c occupies bits [c*COEF_W +: COEF_W].
- newwin  in  1  qualifies dvi: this sample is the last one of the current window.
- clr  in  1  synchronous clear of all accumulators and pointers.
- start_dl  in  1  download request; honoured only in state ACC.
- dl_ready  in  1  downstream ready.
- dvo  out  1  regout valid.
- regout  out  ACC_W  accumulator value being downloaded.
- dl_win  out  clog2(WPI)  window index of regout.
- dl_ch  out  clog2(NCH)  channel index of regout.
- busy  out  1  high in DRAIN and DL.
- done  out  1  one-cycle pulse after the last transfer.
- ovf  out  1  sticky: an overflow occurred in some channel.
- drop  out  1  sticky: dvi was asserted while the block was not in ACC.

Behaviour:
- Reset values: all outputs 0, all accumulators 0, wr_win 0, state ACC.
- Clock and reset: single clock; reset is asynchronous and active-low.
- States:
  - ACC: accumulate.
  - DRAIN: one cycle.
  - DL: stream out.
- Transitions:
  - ACC -> DRAIN on start_dl.
  - DRAIN -> DL unconditionally.
  - DL -> ACC after transfer (WPI-1, NCH-1); done pulses on that cycle+1.
- Accumulate (state ACC, dvi=1):
  - For each channel c: acc[c][wr_win] += sext($signed({1'b0,data}) * coef_c), with the product taken at full width and sign-extended to ACC_W.
  - The result is visible 1 cycle later.
  - If dvi and newwin are both high, wr_win increments after this sample; it wraps WPI-1 -> 0.
  - newwin without dvi is ignored.
- Overflow detection: compute the sum at ACC_W+1 bits. Overflow when the top two bits differ.
  - SAT=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - SAT=0: keep the low ACC_W bits.
  - Either mode sets ovf. ovf clears only on reset or clr.
- start_dl and dvi in the same cycle: the sample is accumulated, then DRAIN.
- Samples arriving in DRAIN or DL are discarded and set drop. drop clears on reset or clr.
- Download order: window-major, channel-minor: (0,0),(0,1),...,(0,NCH-1),(1,0),...,(WPI-1,NCH-1).
- Download handshake:
  - dvo is registered and rises on the first DL cycle.
  - regout, dl_win and dl_ch are stable while dvo=1 and dl_ready=0.
  - A transfer happens on dvo & dl_ready. The read entry is zeroed in that same cycle, and the next entry is presented on the following cycle, so back-to-back transfers run at 1 per clock.
- End of download: after the final transfer, dvo drops, state returns to ACC, wr_win=0, and done pulses for one cycle.
- start_dl while busy is ignored.
- clr (any state, highest priority after reset): on the next edge all accumulators, wr_win, ovf and drop are zeroed and the state goes to ACC. dvo deasserts with no done pulse, so a download in progress is aborted.
- reset_n low mid-operation: immediate return to the reset values.

Test Plan:
- WPI=4, NCH=2, BLOCKSIZE-style 8 samples/window; data=7, coef0=3, coef1=-2 for all samples. Download -> 8 words alternating 168 and -112, dl_win 0..3, done pulse once, all accumulators read 0 afterwards.
- Random data/coef for 16 rows of 32 windows, checked against a scoreboard model; dl_ready toggling randomly -> every word matches, no word lost or duplicated, regout stable while dl_ready=0.
- SAT=1, ACC_W=12; data=255, coef=255, 1 window of 8 samples -> ovf=1, regout=2047. Same with SAT=0 -> wrapped low 12 bits, ovf=1.
- start_dl together with dvi (data=5, coef0=1), then dvi high during DRAIN/DL -> the first sample counts (+5), the rest are dropped, drop=1.
- clr asserted mid-download after 3 transfers -> dvo=0 next cycle, no done pulse, all accumulators 0, ovf=drop=0, state ACC.
- reset_n pulsed low asynchronously during ACC with nonzero accumulators -> all outputs 0 immediately; a following download returns all zeros.
